// File: rtl/wb_sram_arb_pkg.sv
// Shared types and constants for the two-master Wishbone SRAM arbiter.
// Owner encoding doubles as the one-hot grant seen on gnt_o.
package wb_sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } owner_e;

    // Pointing at master 1 makes master 0 win the first contended grant.
    localparam logic LAST_RST = 1'b1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb_sram_arbiter_if.sv
// One Wishbone classic link: the master modport drives the request,
// the slave modport returns read data and ack.
interface wb_sram_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic              cyc;
    logic              stb;
    logic              we;
    logic [DW/8-1:0]   sel;
    logic [AW-1:0]     adr;
    logic [DW-1:0]     dat_w;
    logic [DW-1:0]     dat_r;
    logic              ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack
    );

endinterface

// File: rtl/wb_arb_rr_pick.sv
// Combinational 2-way round-robin choice: a lone requester wins, and on a tie
// the master that did not own the bus last wins. Returns a one-hot grant.
module wb_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Round-robin, cycle-locked Wishbone arbiter sharing one SRAM port between two masters.
// Define WB_SRAM_ARB_TIMEOUT_EN to add the stalled-slave watchdog.
module wb_sram_arbiter
    import wb_sram_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    wb_sram_arbiter_if.slave         m0,
    wb_sram_arbiter_if.slave         m1,
    wb_sram_arbiter_if.master        s,
    output logic [1:0]               gnt_o,
    output logic                     timeout_o
);

    typedef struct packed {
        logic            cyc;
        logic            stb;
        logic            we;
        logic [DW/8-1:0] sel;
        logic [AW-1:0]   adr;
        logic [DW-1:0]   dat;
    } req_t;

    owner_e     owner;
    owner_e     owner_nxt;
    logic       last;
    logic       arb_point;
    logic [1:0] pick;
    logic       abort;
    req_t       m0_req;
    req_t       m1_req;
    req_t       fwd;

    assign m0_req = '{m0.cyc, m0.stb, m0.we, m0.sel, m0.adr, m0.dat_w};
    assign m1_req = '{m1.cyc, m1.stb, m1.we, m1.sel, m1.adr, m1.dat_w};

    wb_arb_rr_pick u_pick (
        .req  ({m1.cyc, m0.cyc}),
        .last (last),
        .gnt  (pick)
    );

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        arb_point = 1'b1;
        unique case (owner)
            OWN0:    arb_point = !m0.cyc;
            OWN1:    arb_point = !m1.cyc;
            default: arb_point = 1'b1;
        endcase
        owner_nxt = arb_point ? owner_e'(pick) : owner;
    end

    // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            owner <= IDLE;
            last  <= LAST_RST;
        end else begin
            owner <= owner_nxt;
            if (arb_point && (pick != 2'b00))
                last <= pick[1];
        end
    end

`ifdef WB_SRAM_ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] stall_cnt;
    logic          timeout_q;

    assign abort     = (stall_cnt == TO_LIMIT) && (owner != IDLE);
    assign timeout_o = timeout_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (abort || s.ack || (owner_nxt != owner))
                stall_cnt <= '0;
            else if (s.stb && !s.ack)
                stall_cnt <= stall_cnt + 1'b1;
            if (abort)
                timeout_q <= 1'b1;
        end
    end
`else
    // Without the watchdog a stalled slave holds the owner; TIMEOUT_CYCLES has no effect.
    assign abort     = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        fwd      = '0;
        m0.ack   = 1'b0;
        m0.dat_r = '0;
        m1.ack   = 1'b0;
        m1.dat_r = '0;
        unique case (owner)
            OWN0: begin
                fwd      = m0_req;
                m0.ack   = s.ack;
                m0.dat_r = s.dat_r;
            end
            OWN1: begin
                fwd      = m1_req;
                m1.ack   = s.ack;
                m1.dat_r = s.dat_r;
            end
            default: ;
        endcase
        // An aborted beat is completed towards the owner while the SRAM sees an idle bus.
        if (abort) begin
            fwd.cyc = 1'b0;
            fwd.stb = 1'b0;
            if (owner == OWN0) begin
                m0.ack   = 1'b1;
                m0.dat_r = DW'(TIMEOUT_DATA);
            end else begin
                m1.ack   = 1'b1;
                m1.dat_r = DW'(TIMEOUT_DATA);
            end
        end
    end

    assign s.cyc   = fwd.cyc;
    assign s.stb   = fwd.stb;
    assign s.we    = fwd.we;
    assign s.sel   = fwd.sel;
    assign s.adr   = fwd.adr;
    assign s.dat_w = fwd.dat;
    assign gnt_o   = owner;

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Self-checking bench for wb_sram_arbiter: vector table of single beats, an ack
// scoreboard, and hand sequences for reset, contention, lock, watchdog and mid-op reset.
module tb_wb_sram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic [1:0] gnt;
    logic timeout;

    always #5 clk = ~clk;

    wb_sram_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
    wb_sram_arbiter_if #(.AW(32), .DW(32)) m1_bus ();
    wb_sram_arbiter_if #(.AW(32), .DW(32)) s_bus ();

    wb_sram_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .s         (s_bus),
        .gnt_o     (gnt),
        .timeout_o (timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- SRAM slave model: registered ack, byte-lane writes
    logic [31:0] mem [0:255];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            s_bus.ack <= 1'b0;
        end else if (s_bus.cyc && s_bus.stb && !s_bus.ack && !stall) begin
            s_bus.ack <= 1'b1;
            if (s_bus.we) begin
                mem[s_bus.adr[9:2]] <= merge(mem[s_bus.adr[9:2]], s_bus.dat_w, s_bus.sel);
                s_bus.dat_r <= 32'h0;
            end else begin
                s_bus.dat_r <= mem[s_bus.adr[9:2]];
            end
        end else begin
            s_bus.ack <= 1'b0;
        end
    end

    // ---------------- ack scoreboard
    typedef struct {
        int          master;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin : monitor
        int          k;
        logic [31:0] d;
        exp_t        e;
        if (m0_bus.ack || m1_bus.ack) begin
            check("ack_onehot", {31'b0, m0_bus.ack & m1_bus.ack}, 32'h0);
            k = m1_bus.ack ? 1 : 0;
            d = m1_bus.ack ? m1_bus.dat_r : m0_bus.dat_r;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(k), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("ack_master", 32'(k), 32'(e.master));
                if (e.chk) check("ack_data", d, e.data);
            end
        end
    end

    // Every edge with a live request and no reset must leave the bus owned.
    logic cyc_at_edge = 1'b0;
    logic rst_at_edge = 1'b1;
    int   bubbles = 0;
    always @(posedge clk) begin
        cyc_at_edge <= m0_bus.cyc | m1_bus.cyc;
        rst_at_edge <= rst;
    end
    always @(negedge clk)
        if (!rst_at_edge && cyc_at_edge && gnt == 2'b00) bubbles++;

    // ---------------- master drivers
    task automatic set_req(input int k, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (k == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
            m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
            m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
        end
    endtask

    function automatic logic get_ack(input int k);
        return (k == 0) ? m0_bus.ack : m1_bus.ack;
    endfunction

    task automatic do_beat(input int k, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        logic got;
        @(negedge clk);
        set_req(k, 1'b1, 1'b1, we, adr, dat, sel);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (get_ack(k)) got = 1'b1;
        end
        set_req(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check($sformatf("beat_ack_m%0d", k), {31'b0, got}, 32'h1);
    endtask

    task automatic lock_burst();
        int n;
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h1111_0000, 4'hF);
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (m0_bus.ack) begin
                check("lock_gnt", {30'b0, gnt}, 32'h1);
                n++;
                if (n < 4)
                    set_req(0, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * n), 32'h1111_0000 + 32'(n), 4'hF);
                else
                    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
        end
        check("lock_beats", 32'(n), 32'd4);
        @(negedge clk);
        check("lock_handover_gnt", {30'b0, gnt}, 32'h2);
    endtask

    // ---------------- vectors
    typedef struct {
        int          master;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    initial begin : global_limit
        #200000;
        $display("FAIL global_time_limit: got stuck expected finish");
        $fatal(1);
    end

    initial begin : stim
        int   n;
        int   acks;
        logic got;

        vecs[0] = '{0, 1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, 32'h0};
        vecs[1] = '{0, 1'b0, 32'h3000_0010, 32'h0,         4'hF, 32'h1234_5678};
        vecs[2] = '{1, 1'b1, 32'h3000_0020, 32'hA5A5_0000, 4'hF, 32'h0};
        vecs[3] = '{1, 1'b0, 32'h3000_0010, 32'h0,         4'hF, 32'h1234_5678};
        vecs[4] = '{0, 1'b1, 32'h3000_0020, 32'h0000_00FF, 4'h1, 32'h0};
        vecs[5] = '{0, 1'b0, 32'h3000_0020, 32'h0,         4'hF, 32'hA5A5_00FF};
        vecs[6] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h0};
        vecs[7] = '{1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[8] = '{1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hFFFF_FFFF};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        s_bus.dat_r = 32'h0;

        // Reset held 3 cycles with both masters requesting.
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_gnt", {30'b0, gnt}, 32'h0);
            check("rst_s_cyc", {31'b0, s_bus.cyc}, 32'h0);
            check("rst_acks", {30'b0, m1_bus.ack, m0_bus.ack}, 32'h0);
            check("rst_timeout", {31'b0, timeout}, 32'h0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_gnt", {30'b0, gnt}, 32'h0);
        @(negedge clk);
        check("first_grant_m0", {30'b0, gnt}, 32'h1);
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("release_idle", {30'b0, gnt}, 32'h0);

        // Single write with forwarding checks, then readback.
        sb.push_back('{0, 1'b0, 32'h0});
        set_req(0, 1'b1, 1'b1, 1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF);
        #1;
        check("grant_latency_pre", {30'b0, gnt}, 32'h0);
        @(negedge clk);
        check("single_gnt", {30'b0, gnt}, 32'h1);
        check("single_s_cyc", {31'b0, s_bus.cyc}, 32'h1);
        check("single_s_we", {31'b0, s_bus.we}, 32'h1);
        check("single_s_adr", s_bus.adr, 32'h3000_0010);
        check("single_s_dat", s_bus.dat_w, 32'h1234_5678);
        check("single_s_sel", {28'b0, s_bus.sel}, 32'hF);
        check("single_m0_ack_wait", {31'b0, m0_bus.ack}, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (s_bus.ack) begin
                got = 1'b1;
                check("single_m0_ack_mirror", {31'b0, m0_bus.ack}, 32'h1);
                check("single_m1_ack", {31'b0, m1_bus.ack}, 32'h0);
            end
        end
        check("single_s_ack_seen", {31'b0, got}, 32'h1);
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sb.push_back('{0, 1'b1, 32'h1234_5678});
        do_beat(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF);

        // Table of single beats.
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{vecs[i].master, !vecs[i].we, vecs[i].exp_rd});
            do_beat(vecs[i].master, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
        end

        // Contention: both masters, two beats each, alternating grants.
        sb.push_back('{0, 1'b0, 32'h0});
        sb.push_back('{1, 1'b0, 32'h0});
        sb.push_back('{0, 1'b1, 32'hCAFE_0000});
        sb.push_back('{1, 1'b1, 32'h0000_BEEF});
        fork
            begin
                do_beat(0, 1'b1, 32'h40, 32'hCAFE_0000, 4'hF);
                do_beat(0, 1'b0, 32'h40, 32'h0, 4'hF);
            end
            begin
                do_beat(1, 1'b1, 32'h44, 32'h0000_BEEF, 4'hF);
                do_beat(1, 1'b0, 32'h44, 32'h0, 4'hF);
            end
        join

        // Lock: m0 bursts 4 beats while m1 waits.
        for (int i = 0; i < 4; i++) sb.push_back('{0, 1'b0, 32'h0});
        sb.push_back('{1, 1'b1, 32'h1234_5678});
        fork
            lock_burst();
            do_beat(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
        join
        sb.push_back('{0, 1'b1, 32'h1111_0002});
        do_beat(0, 1'b0, 32'h108, 32'h0, 4'hF);

        // Stalled slave.
        stall = 1'b1;
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
`ifdef WB_SRAM_ARB_TIMEOUT_EN
        sb.push_back('{1, 1'b1, 32'hDEAD_BEEF});
        n = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (m1_bus.ack) begin
                got = 1'b1;
                n = i;
                check("timeout_dat", m1_bus.dat_r, 32'hDEAD_BEEF);
                check("timeout_s_cyc", {31'b0, s_bus.cyc}, 32'h0);
            end
        end
        check("timeout_latency", 32'(n), 32'd9);
        @(negedge clk);
        check("timeout_ack_width", {31'b0, m1_bus.ack}, 32'h0);
        check("timeout_flag", {31'b0, timeout}, 32'h1);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("timeout_flag_sticky", {31'b0, timeout}, 32'h1);
        check("timeout_release_gnt", {30'b0, gnt}, 32'h0);
`else
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m1_bus.ack) acks++;
        end
        check("stall_no_ack", 32'(acks), 32'd0);
        check("stall_timeout_off", {31'b0, timeout}, 32'h0);
        check("stall_still_owned", {30'b0, gnt}, 32'h2);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("drop_without_ack_gnt", {30'b0, gnt}, 32'h0);
`endif

        // Mid-operation reset with m1 pending.
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("midrst_pre_gnt", {30'b0, gnt}, 32'h2);
        check("midrst_pre_stb", {31'b0, s_bus.stb}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gnt", {30'b0, gnt}, 32'h0);
        check("midrst_s_cyc", {31'b0, s_bus.cyc}, 32'h0);
        check("midrst_m1_ack", {31'b0, m1_bus.ack}, 32'h0);
        check("midrst_timeout", {31'b0, timeout}, 32'h0);
        rst = 1'b0;
        stall = 1'b0;
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Recovery: m1 retries its read.
        sb.push_back('{1, 1'b1, 32'h1234_5678});
        do_beat(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("no_idle_bubble", 32'(bubbles), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
